// File: rtl/mem_wb_stage.sv
// MEM stage of the five-stage MIPS pipeline plus the MEM/WB register.
// It performs the data-memory access, resolves branches and registers the write-back inputs.
module mem_wb_stage #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        RegWrite_in,
    input  logic        MemToReg_in,
    input  logic        Branch_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  MemSize_in,
    input  logic        MemSigned_in,
    input  logic [31:0] BranchTarget_in,
    input  logic        ALUZero_in,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] WriteData_in,
    input  logic [4:0]  DestReg_in,
    output logic        PCSrc,
    output logic [31:0] BranchTarget_out,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic [31:0] ReadData_out,
    output logic [31:0] ALUResult_out,
    output logic [4:0]  DestReg_out,
    output logic        AddrError,
    output logic [31:0] WBData
);
    localparam int IW = $clog2(DEPTH_WORDS);

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  dest_reg;
        logic        addr_error;
    } mem_wb_t;

    mem_wb_t wb_d, wb_q;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [IW-1:0] idx;
    logic [1:0]    lane;
    logic          is_half, is_byte, is_word, misaligned, addr_error;
    logic [3:0]    byte_en;
    logic [31:0]   store_data, rd_word, load_data;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;

    assign idx     = ALUResult_in[IW+1:2];
    assign lane    = ALUResult_in[1:0];
    assign is_half = (MemSize_in == 2'b01);
    assign is_byte = (MemSize_in == 2'b10);
    assign is_word = !is_half && !is_byte;

    assign misaligned = (is_word && lane != 2'b00) || (is_half && lane[0]);
    // Only real memory accesses can fault; ALU ops carry arbitrary results here.
    assign addr_error = (MemRead_in || MemWrite_in) && misaligned;

    always_comb begin
        byte_en    = 4'b1111;
        store_data = WriteData_in;
        if (is_byte) begin
            byte_en    = 4'b0001 << lane;
            store_data = {4{WriteData_in[7:0]}};
        end else if (is_half) begin
            byte_en    = lane[1] ? 4'b1100 : 4'b0011;
            store_data = {2{WriteData_in[15:0]}};
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst && !Stall && MemWrite_in && !misaligned) begin
            for (int k = 0; k < 4; k++)
                if (byte_en[k]) mem[idx][8*k +: 8] <= store_data[8*k +: 8];
        end
    end

    assign rd_word = mem[idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_data = 32'h0;
        if (MemRead_in && !misaligned) begin
            if (is_byte)      load_data = {{24{MemSigned_in & rd_byte[7]}}, rd_byte};
            else if (is_half) load_data = {{16{MemSigned_in & rd_half[15]}}, rd_half};
            else              load_data = rd_word;
        end
    end

    always_comb begin
        wb_d.reg_write  = RegWrite_in && !addr_error;
        wb_d.mem_to_reg = MemToReg_in;
        wb_d.read_data  = load_data;
        wb_d.alu_result = ALUResult_in;
        wb_d.dest_reg   = DestReg_in;
        wb_d.addr_error = addr_error;
    end

    always_ff @(posedge Clk) begin
        if (Rst)         wb_q <= '0;
        else if (!Stall) wb_q <= wb_d;
    end

    assign RegWrite_out  = wb_q.reg_write;
    assign MemToReg_out  = wb_q.mem_to_reg;
    assign ReadData_out  = wb_q.read_data;
    assign ALUResult_out = wb_q.alu_result;
    assign DestReg_out   = wb_q.dest_reg;
    assign AddrError     = wb_q.addr_error;
    assign WBData        = wb_q.mem_to_reg ? wb_q.read_data : wb_q.alu_result;

    assign PCSrc            = Branch_in & ALUZero_in;
    assign BranchTarget_out = BranchTarget_in;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, stall/reset sequences,
// then a randomized stream checked against a byte-array memory model.
module tb_mem_wb_stage;
    logic        Clk = 1'b0, Rst = 1'b1, Stall = 1'b0;
    logic        RegWrite_in = 0, MemToReg_in = 0, Branch_in = 0, MemRead_in = 0, MemWrite_in = 0;
    logic [1:0]  MemSize_in = 0;
    logic        MemSigned_in = 0, ALUZero_in = 0;
    logic [31:0] BranchTarget_in = 0, ALUResult_in = 0, WriteData_in = 0;
    logic [4:0]  DestReg_in = 0;
    logic        PCSrc, RegWrite_out, MemToReg_out, AddrError;
    logic [31:0] BranchTarget_out, ReadData_out, ALUResult_out, WBData;
    logic [4:0]  DestReg_out;

    int compared = 0, mismatched = 0;

    mem_wb_stage #(.DEPTH_WORDS(1024)) dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall),
        .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in), .Branch_in(Branch_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .MemSize_in(MemSize_in),
        .MemSigned_in(MemSigned_in), .BranchTarget_in(BranchTarget_in), .ALUZero_in(ALUZero_in),
        .ALUResult_in(ALUResult_in), .WriteData_in(WriteData_in), .DestReg_in(DestReg_in),
        .PCSrc(PCSrc), .BranchTarget_out(BranchTarget_out), .RegWrite_out(RegWrite_out),
        .MemToReg_out(MemToReg_out), .ReadData_out(ReadData_out), .ALUResult_out(ALUResult_out),
        .DestReg_out(DestReg_out), .AddrError(AddrError), .WBData(WBData)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic st, ld; logic [1:0] sz; logic sg;
        logic [31:0] a, wd; logic rw, m2r; logic [4:0] dst;
        logic [31:0] erd, ewb; logic eae, erw;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic st, logic ld, logic [1:0] sz, logic sg, logic [31:0] a,
                               logic [31:0] wd, logic rw, logic m2r, logic [4:0] dst,
                               logic [31:0] erd, logic [31:0] ewb, logic eae, logic erw);
        vec_t r;
        r.st = st; r.ld = ld; r.sz = sz; r.sg = sg; r.a = a; r.wd = wd;
        r.rw = rw; r.m2r = m2r; r.dst = dst; r.erd = erd; r.ewb = ewb; r.eae = eae; r.erw = erw;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic ld, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic rw,
                         input logic m2r, input logic [4:0] dst);
        MemWrite_in = st; MemRead_in = ld; MemSize_in = sz; MemSigned_in = sg;
        ALUResult_in = a; WriteData_in = wd; RegWrite_in = rw; MemToReg_in = m2r; DestReg_in = dst;
    endtask

    task automatic tick();
        @(posedge Clk); #1;
    endtask

    task automatic chk_regs(input string nm, input logic [31:0] rd, input logic [31:0] alu,
                            input logic [4:0] dst, input logic rw, input logic m2r, input logic ae);
        chk({nm, ".rd"}, ReadData_out, rd);
        chk({nm, ".alu"}, ALUResult_out, alu);
        chk({nm, ".dst"}, {27'b0, DestReg_out}, {27'b0, dst});
        chk({nm, ".rw"}, {31'b0, RegWrite_out}, {31'b0, rw});
        chk({nm, ".m2r"}, {31'b0, MemToReg_out}, {31'b0, m2r});
        chk({nm, ".ae"}, {31'b0, AddrError}, {31'b0, ae});
        chk({nm, ".wb"}, WBData, m2r ? rd : alu);
    endtask

    // Randomized-phase reference: 64-byte window at 0x100, aliased every 4 KiB.
    logic [7:0]  mm [64];
    logic [31:0] m_rd, m_alu;
    logic [4:0]  m_dst;
    logic        m_rw, m_m2r, m_ae;

    initial begin
        // Reset with garbage on the inputs, including a store.
        drive(1, 1, 0, 1, 32'h0000_0010, 32'hFFFF_FFFF, 1, 1, 5'd31);
        Stall = 1'b0;
        tick();
        chk_regs("reset", 0, 0, 0, 0, 0, 0);
        Rst = 1'b0;

        //            st ld sz sg addr          wdata         rw m2r dst  exp_rd        exp_wb        ae rw
        tbl.push_back(v(0, 0, 0, 0, 32'h42,       32'h0,        1, 0, 5,  32'h0,        32'h42,       0, 1));
        tbl.push_back(v(1, 0, 0, 0, 32'h10,       32'hDEADBEEF, 0, 0, 0,  32'h0,        32'h10,       0, 0));
        tbl.push_back(v(0, 1, 0, 0, 32'h10,       32'h0,        1, 1, 8,  32'hDEADBEEF, 32'hDEADBEEF, 0, 1));
        tbl.push_back(v(0, 1, 2, 1, 32'h13,       32'h0,        1, 1, 9,  32'hFFFFFFDE, 32'hFFFFFFDE, 0, 1));
        tbl.push_back(v(0, 1, 2, 0, 32'h13,       32'h0,        1, 1, 10, 32'h000000DE, 32'h000000DE, 0, 1));
        tbl.push_back(v(0, 1, 1, 1, 32'h12,       32'h0,        1, 1, 11, 32'hFFFFDEAD, 32'hFFFFDEAD, 0, 1));
        tbl.push_back(v(1, 0, 2, 0, 32'h11,       32'hFFFFFF55, 0, 0, 0,  32'h0,        32'h11,       0, 0));
        tbl.push_back(v(0, 1, 0, 0, 32'h10,       32'h0,        1, 1, 1,  32'hDEAD55EF, 32'hDEAD55EF, 0, 1));
        tbl.push_back(v(1, 0, 1, 0, 32'h12,       32'hABCD1234, 0, 0, 0,  32'h0,        32'h12,       0, 0));
        tbl.push_back(v(0, 1, 0, 0, 32'h10,       32'h0,        1, 1, 2,  32'h123455EF, 32'h123455EF, 0, 1));
        tbl.push_back(v(0, 1, 0, 0, 32'h6,        32'h0,        1, 1, 12, 32'h0,        32'h0,        1, 0));
        tbl.push_back(v(1, 0, 0, 0, 32'h20,       32'hCAFEF00D, 0, 0, 0,  32'h0,        32'h20,       0, 0));
        tbl.push_back(v(1, 0, 1, 0, 32'h21,       32'h0000BEEF, 0, 0, 0,  32'h0,        32'h21,       1, 0));
        tbl.push_back(v(0, 1, 0, 0, 32'h20,       32'h0,        1, 1, 13, 32'hCAFEF00D, 32'hCAFEF00D, 0, 1));
        tbl.push_back(v(0, 1, 1, 0, 32'h22,       32'h0,        1, 1, 14, 32'h0000CAFE, 32'h0000CAFE, 0, 1));
        tbl.push_back(v(0, 1, 1, 1, 32'h20,       32'h0,        1, 1, 15, 32'hFFFFF00D, 32'hFFFFF00D, 0, 1));
        tbl.push_back(v(0, 1, 2, 1, 32'h21,       32'h0,        1, 1, 16, 32'hFFFFFFF0, 32'hFFFFFFF0, 0, 1));
        tbl.push_back(v(0, 1, 2, 0, 32'h22,       32'h0,        1, 1, 17, 32'h000000FE, 32'h000000FE, 0, 1));
        tbl.push_back(v(0, 1, 3, 1, 32'h20,       32'h0,        1, 1, 18, 32'hCAFEF00D, 32'hCAFEF00D, 0, 1));
        tbl.push_back(v(0, 1, 0, 0, 32'h1020,     32'h0,        1, 1, 19, 32'hCAFEF00D, 32'hCAFEF00D, 0, 1));
        tbl.push_back(v(0, 1, 1, 1, 32'h23,       32'h0,        1, 1, 20, 32'h0,        32'h0,        1, 0));
        tbl.push_back(v(0, 0, 0, 0, 32'h7,        32'h0,        1, 0, 3,  32'h0,        32'h7,        0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].ld, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd,
                  tbl[i].rw, tbl[i].m2r, tbl[i].dst);
            tick();
            chk($sformatf("vec%0d.rd", i), ReadData_out, tbl[i].erd);
            chk($sformatf("vec%0d.wb", i), WBData, tbl[i].ewb);
            chk($sformatf("vec%0d.ae", i), {31'b0, AddrError}, {31'b0, tbl[i].eae});
            chk($sformatf("vec%0d.rw", i), {31'b0, RegWrite_out}, {31'b0, tbl[i].erw});
            chk($sformatf("vec%0d.dst", i), {27'b0, DestReg_out}, {27'b0, tbl[i].dst});
        end

        // Stalled store is suppressed and outputs hold.
        drive(1, 0, 0, 0, 32'h40, 32'h11111111, 0, 0, 0); tick();
        Stall = 1'b1;
        drive(1, 0, 0, 0, 32'h40, 32'hAAAAAAAA, 1, 1, 7);
        repeat (2) begin tick(); chk_regs("stall_hold", 0, 32'h40, 0, 0, 0, 0); end
        Stall = 1'b0;
        drive(0, 1, 0, 0, 32'h40, 0, 1, 1, 4); tick();
        chk_regs("stall_nowrite", 32'h11111111, 32'h40, 4, 1, 1, 0);
        // Stall then release with the store still presented.
        Stall = 1'b1;
        drive(1, 0, 0, 0, 32'h40, 32'hAAAAAAAA, 0, 0, 0);
        repeat (2) begin tick(); chk_regs("stall_hold2", 32'h11111111, 32'h40, 4, 1, 1, 0); end
        Stall = 1'b0; tick();
        chk_regs("stall_release", 0, 32'h40, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 32'h40, 0, 1, 1, 6); tick();
        chk_regs("stall_lw", 32'hAAAAAAAA, 32'h40, 6, 1, 1, 0);

        // Reset mid-stream beats Stall and discards the in-flight store.
        Rst = 1'b1; Stall = 1'b1;
        drive(1, 0, 0, 0, 32'h40, 32'h77777777, 1, 0, 9); tick();
        chk_regs("rst_mid", 0, 0, 0, 0, 0, 0);
        Rst = 1'b0; Stall = 1'b0;
        drive(0, 1, 0, 0, 32'h40, 0, 1, 1, 6); tick();
        chk_regs("rst_nostore", 32'hAAAAAAAA, 32'h40, 6, 1, 1, 0);

        // Branch resolution is combinational and ignores Stall.
        Stall = 1'b1; Branch_in = 1; ALUZero_in = 1; BranchTarget_in = 32'h100; #1;
        chk("br_taken", {31'b0, PCSrc}, 32'd1);
        chk("br_target", BranchTarget_out, 32'h100);
        ALUZero_in = 0; #1;
        chk("br_nz", {31'b0, PCSrc}, 32'd0);
        Branch_in = 0; ALUZero_in = 1; #1;
        chk("br_nobranch", {31'b0, PCSrc}, 32'd0);
        Stall = 1'b0;

        // Randomized stream; starts from reset so the model state is all zero.
        Rst = 1'b1; tick(); Rst = 1'b0;
        m_rd = 0; m_alu = 0; m_dst = 0; m_rw = 0; m_m2r = 0; m_ae = 0;
        for (int n = 0; n < 416; n++) begin
            int kind, nb, off;
            logic [1:0]  sz;
            logic [31:0] a, wd, val;
            logic sg, rw, m2r, st, ld, mis, stall, b, z;
            logic [4:0] dst;
            if (n < 16) begin
                kind = 2; sz = 0; off = 4 * n; stall = 0;
            end else begin
                kind = $urandom_range(0, 2); sz = 2'($urandom_range(0, 3));
                stall = ($urandom_range(0, 4) == 0);
                off = $urandom_range(0, 63);
            end
            nb = (sz == 2'd1) ? 2 : (sz == 2'd2) ? 1 : 4;
            if (n >= 16 && $urandom_range(0, 3) != 0) off = off - (off % nb);
            a   = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'(off));
            wd  = $urandom; sg = 1'($urandom); rw = 1'($urandom); m2r = 1'($urandom);
            dst = 5'($urandom); b = 1'($urandom); z = 1'($urandom);
            st  = (kind == 2); ld = (kind == 1);
            mis = (off % nb) != 0;

            val = 0;
            for (int i = 0; i < nb; i++) val |= 32'(mm[(off + i) % 64]) << (8 * i);
            if (sg && nb < 4 && val[8*nb-1]) val |= 32'hFFFF_FFFF << (8 * nb);

            Stall = stall; Branch_in = b; ALUZero_in = z; BranchTarget_in = $urandom;
            drive(st, ld, sz, sg, a, wd, rw, m2r, dst);
            #1;
            chk($sformatf("rnd%0d.pcsrc", n), {31'b0, PCSrc}, {31'b0, b & z});
            chk($sformatf("rnd%0d.bt", n), BranchTarget_out, BranchTarget_in);

            if (!stall) begin
                m_rd  = (ld && !mis) ? val : 32'h0;
                m_alu = a; m_dst = dst; m_m2r = m2r;
                m_ae  = (ld || st) && mis;
                m_rw  = rw && !m_ae;
                if (st && !mis)
                    for (int i = 0; i < nb; i++) mm[off + i] = wd[8*i +: 8];
            end
            tick();
            chk_regs($sformatf("rnd%0d", n), m_rd, m_alu, m_dst, m_rw, m_m2r, m_ae);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage of the five-stage MIPS pipeline plus the MEM/WB pipeline register: the consuming end of the EX/MEM register. It takes the EX/MEM control and data outputs, performs the data-memory access (word, half, byte; signed/unsigned loads), and resolves the branch decision back to the fetch stage. It registers everything the write-back stage needs, with stall and misalignment handling.

## Interface
Parameters:
- DEPTH_WORDS, 1024: data-memory depth in 32-bit words; index is ALUResult_in[log2(DEPTH_WORDS)+1:2].

Ports:
- Clk  in  1  rising-edge clock (only clock)
- Rst  in  1  reset, synchronous, active-high
- Stall  in  1  freeze MEM/WB register and suppress memory write this cycle
- RegWrite_in  in  1  WB control: write register file
- MemToReg_in  in  1  WB control: 1 = write-back load data, 0 = ALU result
- Branch_in  in  1  M control: instruction is a branch
- MemRead_in  in  1  M control: load
- MemWrite_in  in  1  M control: store
- MemSize_in  in  2  00 word, 01 half, 10 byte, 11 treated as word
- MemSigned_in  in  1  1 = sign-extend half/byte loads
- BranchTarget_in  in  32  branch target from EX adder
- ALUZero_in  in  1  ALU zero flag
- ALUResult_in  in  32  ALU result / effective address
- WriteData_in  in  32  store data (rt value)
- DestReg_in  in  5  destination register number
- PCSrc  out  1  combinational: Branch_in & ALUZero_in
- BranchTarget_out  out  32  combinational pass-through of BranchTarget_in
- RegWrite_out  out  1  registered
- MemToReg_out  out  1  registered
- ReadData_out  out  32  registered, extended load data
- ALUResult_out  out  32  registered
- DestReg_out  out  5  registered
- AddrError  out  1  registered misaligned-access flag
- WBData  out  32  combinational: MemToReg_out ? ReadData_out : ALUResult_out

## Operation
- Byte order little-endian: byte lane k = word bits [8k+7:8k], k = addr[1:0]; half lane h = addr[1], bits [16h+15:16h].
- Misaligned: word with addr[1:0] != 0, or half with addr[0] = 1. Misaligned store: no memory write. Misaligned load: ReadData_out = 0. Either: AddrError = 1, RegWrite_out = 0 for that instruction.
- Store: on rising edge when MemWrite_in & !Stall & !Rst & aligned, write only the addressed lanes; other bytes of the word unchanged. Word store writes all four lanes from WriteData_in; half uses WriteData_in[15:0]; byte uses [7:0].
- Load: memory read is combinational on the word index; the selected lane is zero- or sign-extended per MemSigned_in, then registered into ReadData_out. Word loads ignore MemSigned_in.
- When MemRead_in = 0, ReadData_out captures 0.
- Address bits above the index range are ignored (address wraps modulo DEPTH_WORDS*4).
- Memory contents are not affected by Rst; simulation initial contents are all zero.
- PCSrc/BranchTarget_out are purely combinational from current inputs and are not gated by Stall.

## Timing
- Reset (Rst = 1 at rising edge): RegWrite_out = 0, MemToReg_out = 0, ReadData_out = 0, ALUResult_out = 0, DestReg_out = 0, AddrError = 0; no memory write. Rst has priority over Stall.
- Latency: inputs present in cycle N appear on registered outputs after edge N (one-cycle MEM/WB delay); WBData valid in cycle N+1.
- Stall = 1: all registered outputs hold; store suppressed. The instruction is re-presented by upstream logic, and the store occurs once when Stall drops.
- Store in cycle N followed by a load of the same address in cycle N+1 returns the newly written data.
- Rst asserted mid-stream discards the in-flight instruction, including its store.

## Test plan
- Rst high 1 cycle -> all registered outputs 0; then ALU op (RegWrite_in = 1, MemToReg_in = 0, ALUResult_in = 0x0000_0042, DestReg_in = 5) -> next cycle WBData = 0x42, DestReg_out = 5.
- sw 0xDEADBEEF @0x10, then lw @0x10 -> ReadData_out = 0xDEADBEEF; lb @0x13 signed -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lh @0x12 signed -> 0xFFFFDEAD.
- sb 0x55 @0x11 over 0xDEADBEEF, then lw @0x10 -> 0xDEAD55EF; sh 0x1234 @0x12 -> lw 0x123455EF.
- lw @0x6 (misaligned) -> AddrError = 1, RegWrite_out = 0, ReadData_out = 0; sh @0x21 -> no memory change (lw @0x20 unchanged), AddrError = 1.
- Store 0xAAAA_AAAA @0x40 with Stall = 1 for 2 cycles -> outputs hold and memory unchanged; Stall drops -> write happens once, and lw @0x40 returns 0xAAAAAAAA.
- Branch_in = 1, ALUZero_in = 1, BranchTarget_in = 0x0000_0100 -> same-cycle PCSrc = 1, BranchTarget_out = 0x100; ALUZero_in = 0 -> PCSrc = 0.
